// File: rtl/bin_frame_packetizer.sv
// Frames each collected bin vector as one header word plus BINS zero-extended data words.
// A one-deep pending buffer absorbs a vector that arrives mid-frame; later arrivals are dropped.
module bin_frame_packetizer #(
  parameter int unsigned BINS  = 4,
  parameter int unsigned N     = 16,
  parameter logic [15:0] MAGIC = 16'hB1A5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BINS*N-1:0] in_bins,
  input  logic              in_valid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [15:0]       seq_num,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int unsigned IW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(BINS - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e                 state_q;
  logic [BINS-1:0][N-1:0] in_vec;
  logic [BINS-1:0][N-1:0] frame_q;
  logic [BINS-1:0][N-1:0] pend_q;
  logic                   pend_full_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_inc;
  logic [15:0]            seq_inc;
  logic                   hs;
  logic                   last_hs;

  assign in_vec  = in_bins;
  assign seq_inc = seq_num + 16'd1;
  assign idx_inc = idx_q + 1'b1;
  assign hs      = out_valid & out_ready;
  assign last_hs = hs && (state_q == StData) && (idx_q == LastIdx);
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      seq_num     <= '0;
      drop_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            frame_q   <= in_vec;
            seq_num   <= seq_inc;
            state_q   <= StHdr;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= {MAGIC, seq_inc};
          end
        end
        StHdr: begin
          if (hs) begin
            state_q   <= StData;
            idx_q     <= '0;
            out_first <= 1'b0;
            out_last  <= (BINS == 1);
            out_data  <= 32'(frame_q[0]);
          end
        end
        StData: begin
          if (hs) begin
            if (idx_q == LastIdx) begin
              // Pending vector takes precedence over a same-cycle arrival
              if (pend_full_q || in_valid) begin
                frame_q   <= pend_full_q ? pend_q : in_vec;
                seq_num   <= seq_inc;
                state_q   <= StHdr;
                out_first <= 1'b1;
                out_last  <= 1'b0;
                out_data  <= {MAGIC, seq_inc};
              end else begin
                state_q   <= StIdle;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              idx_q    <= idx_inc;
              out_data <= 32'(frame_q[idx_inc]);
              out_last <= (idx_inc == LastIdx);
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if ((state_q != StIdle) && in_valid) begin
        if (last_hs) begin
          // Pending moves to the frame buffer above, so the arrival refills it
          if (pend_full_q) pend_q <= in_vec;
        end else if (!pend_full_q) begin
          pend_q      <= in_vec;
          pend_full_q <= 1'b1;
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
      if (last_hs && pend_full_q && !in_valid) pend_full_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_frame_packetizer.sv
// Directed bench for bin_frame_packetizer: framing, stalls, overflow, back-to-back,
// sequence wrap and mid-frame reset, with hand-computed expected words.
module tb_bin_frame_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_bins;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic [15:0] seq_num;
  logic [15:0] drop_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] VecBasic = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] VecA     = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
  localparam logic [63:0] VecB     = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
  localparam logic [63:0] VecC     = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};

  always #5 clk = ~clk;

  bin_frame_packetizer #(
    .BINS (4),
    .N    (16),
    .MAGIC(16'hB1A5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bins  (in_bins),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last (out_last),
    .seq_num  (seq_num),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bins   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bins   = VecBasic;
    tick();
    tick();
    checks++;
    if ({out_valid, out_first, out_last, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got v/f/l/busy=%b want 0000",
               {out_valid, out_first, out_last, busy});
    end
    checks++;
    if (out_data !== 32'h0 || seq_num !== 16'h0 || drop_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: got data=%h seq=%h drop=%h want 0/0/0",
               out_data, seq_num, drop_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp[5] = '{32'hB1A50001, 32'h1, 32'h2, 32'h3, 32'h4};
    do_reset();
    out_ready = 1'b1;
    in_bins   = VecBasic;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_first !== (i == 0) ||
          out_last !== (i == 4)) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b d=%h f=%b l=%b want v=1 d=%h f=%b l=%b",
                 i, out_valid, out_data, out_first, out_last, exp[i], (i == 0), (i == 4));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || seq_num !== 16'd1) begin
      errors++;
      $display("FAIL basic_end: got busy=%b v=%b seq=%h want 0/0/0001", busy, out_valid, seq_num);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp[5] = '{32'hB1A50001, 32'h1, 32'h2, 32'h3, 32'h4};
    int          n = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_first = 1'b0;
    logic        prev_last = 1'b0;
    do_reset();
    in_bins  = VecBasic;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      out_ready = (c % 2 == 0);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_first !== prev_first ||
            out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold c%0d: got v=%b d=%h f=%b l=%b want v=1 d=%h f=%b l=%b",
                   c, out_valid, out_data, out_first, out_last, prev_data, prev_first,
                   prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp[n] || out_first !== (n == 0) || out_last !== (n == 4)) begin
          errors++;
          $display("FAIL stall_word%0d: got d=%h f=%b l=%b want d=%h f=%b l=%b",
                   n, out_data, out_first, out_last, exp[n], (n == 0), (n == 4));
        end
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_first = out_first;
      prev_last  = out_last;
      tick();
    end
    checks++;
    if (n != 5 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: got hs=%0d busy=%b v=%b want 5/0/0", n, busy, out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp[10] = '{32'hB1A50001, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                             32'hB1A50002, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
    do_reset();
    in_valid = 1'b1;
    in_bins  = VecA;
    tick();
    in_bins = VecB;
    tick();
    in_bins = VecC;
    tick();
    in_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'd1 || seq_num !== 16'd1 || out_data !== 32'hB1A50001 ||
        out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_held: got drop=%h seq=%h d=%h v=%b want 0001/0001/b1a50001/1",
               drop_cnt, seq_num, out_data, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_first !== (i % 5 == 0) ||
          out_last !== (i % 5 == 4)) begin
        errors++;
        $display("FAIL ovf_word%0d: got v=%b d=%h f=%b l=%b want v=1 d=%h f=%b l=%b",
                 i, out_valid, out_data, out_first, out_last, exp[i], (i % 5 == 0),
                 (i % 5 == 4));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || seq_num !== 16'd2 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovf_end: got busy=%b seq=%h drop=%h want 0/0002/0001",
               busy, seq_num, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    in_bins   = VecA;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_last !== 1'b1 || out_data !== 32'hA3) begin
      errors++;
      $display("FAIL b2b_last: got l=%b d=%h want 1/000000a3", out_last, out_data);
    end
    in_bins  = VecB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB1A50002 || out_first !== 1'b1 ||
        seq_num !== 16'd2 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL b2b_hdr: got v=%b d=%h f=%b seq=%h drop=%h want 1/b1a50002/1/0002/0000",
               out_valid, out_data, out_first, seq_num, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hB0 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 32'hB0 + 32'(i));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.seq_num = 16'hFFFF;
    #1;
    release dut.seq_num;
    #1;
    checks++;
    if (seq_num !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got seq=%h want ffff", seq_num);
    end
    out_ready = 1'b1;
    in_bins   = VecBasic;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'hB1A50000 || seq_num !== 16'h0 || out_first !== 1'b1) begin
      errors++;
      $display("FAIL wrap_hdr: got d=%h seq=%h f=%b want b1a50000/0000/1",
               out_data, seq_num, out_first);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    in_bins  = VecA;
    tick();
    in_bins = VecB;
    tick();
    in_bins = VecC;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_data !== 32'hA2 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rmid_pre: got d=%h drop=%h want 000000a2/0001", out_data, drop_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || seq_num !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset: got v=%b seq=%h drop=%h busy=%b want 0/0000/0000/0",
               out_valid, seq_num, drop_cnt, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_quiet%0d: got v=%b want 0", i, out_valid);
      end
    end
    in_bins  = VecBasic;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB1A50001 || out_first !== 1'b1) begin
      errors++;
      $display("FAIL rmid_hdr: got v=%b d=%h f=%b want 1/b1a50001/1",
               out_valid, out_data, out_first);
    end
    repeat (6) tick();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bins   = '0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
